param_ring_counter: RTL and testbench

PARAM_RING_COUNTER -- requirements
Module: param_ring_counter

---
 rtl/ring_pkg.sv | 14 +
 rtl/ring_state_check.sv | 34 +++
 rtl/param_ring_counter.sv | 96 +++++++++
 tb/tb_param_ring_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared encodings for the ring/Johnson counter: mode and direction codes and the FSM state type.
package ring_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check for a ring (one-hot) or Johnson (0 or 2 circular transitions) state.
module ring_state_check
    import ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic             legal
);

    logic [5:0] w_ones;
    logic [5:0] w_edges;

    always_comb begin
        w_ones  = '0;
        w_edges = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i])
                w_ones = w_ones + 6'd1;
            if (q[i] != q[(i + 1) % WIDTH])
                w_edges = w_edges + 6'd1;
        end
    end

    always_comb begin
        legal = 1'b0;
        if (mode == MODE_JOHNSON)
            legal = (w_edges == 6'd0) || (w_edges == 6'd2);
        else
            legal = (w_ones == 6'd1);
    end

endmodule

// File: rtl/param_ring_counter.sv
// Parameterised ring/Johnson counter with IDLE/RUN sequencing and registered wrap pulse.
// Optional self-correction of illegal states is enabled by defining RING_SELF_CORRECT_EN.
module param_ring_counter
    import ring_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] qout,
    output logic             wrap,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_mode_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_seed_start;
    logic [WIDTH-1:0] w_seed_run;
    logic [WIDTH-1:0] w_next;
    logic             w_fix;

    // Ring seed is one-hot at bit 0; Johnson seed is all zeros.
    assign w_seed_start = (mode == MODE_JOHNSON) ? '0 : WIDTH'(1);
    assign w_seed_run   = (r_mode_q == MODE_JOHNSON) ? '0 : WIDTH'(1);

    always_comb begin
        w_next = r_q;
        if (r_mode_q == MODE_JOHNSON) begin
            if (dir == DIR_LEFT)
                w_next = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            else
                w_next = {~r_q[0], r_q[WIDTH-1:1]};
        end else begin
            if (dir == DIR_LEFT)
                w_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            else
                w_next = {r_q[0], r_q[WIDTH-1:1]};
        end
    end

`ifdef RING_SELF_CORRECT_EN
    logic w_legal;
    logic r_err;

    ring_state_check #(.WIDTH(WIDTH)) u_check (
        .q     (r_q),
        .mode  (r_mode_q),
        .legal (w_legal)
    );

    assign w_fix = (r_state == RUN) && !w_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else
            r_err <= !start && w_fix;
    end

    assign err = r_err;
`else
    assign w_fix = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_mode_q <= MODE_RING;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (start) begin
                r_state  <= RUN;
                r_mode_q <= mode;
                r_q      <= w_seed_start;
            end else if (w_fix) begin
                r_q <= w_seed_run;
            end else if (r_state == RUN && en) begin
                r_q    <= w_next;
                r_wrap <= (w_next == w_seed_run);
            end
        end
    end

    assign qout = r_q;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_param_ring_counter.sv
// Directed bench for param_ring_counter (WIDTH=4) with an expected-value queue scoreboard.
module tb_param_ring_counter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       en;
    logic       mode;
    logic       dir;
    logic [3:0] qout;
    logic       wrap;
    logic       err;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] q;
        logic       w;
        logic       e;
        string      tag;
    } exp_t;

    exp_t sb[$];

    param_ring_counter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .en    (en),
        .mode  (mode),
        .dir   (dir),
        .qout  (qout),
        .wrap  (wrap),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk();
        exp_t x;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 entries expected=1");
            return;
        end
        x = sb.pop_front();
        n_tests++;
        assert (qout === x.q) else begin
            n_fail++;
            $error("FAIL %s qout observed=%b expected=%b", x.tag, qout, x.q);
        end
        n_tests++;
        assert (wrap === x.w) else begin
            n_fail++;
            $error("FAIL %s wrap observed=%b expected=%b", x.tag, wrap, x.w);
        end
        n_tests++;
        assert (err === x.e) else begin
            n_fail++;
            $error("FAIL %s err observed=%b expected=%b", x.tag, err, x.e);
        end
    endtask

    task automatic step(input logic s, input logic e, input logic m, input logic d,
                        input logic [3:0] eq, input logic ew, input logic ee, input string tag);
        @(negedge clk);
        start = s;
        en    = e;
        mode  = m;
        dir   = d;
        sb.push_back('{eq, ew, ee, tag});
        @(posedge clk);
        #1;
        chk();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        dir   = 1'b0;
        #2;
        sb.push_back('{4'b0000, 1'b0, 1'b0, "reset"});
        chk();
        @(negedge clk);
        rst_n = 1'b1;

        // idle ignores en
        step(0, 1, 0, 0, 4'b0000, 0, 0, "idle0");
        step(0, 1, 0, 0, 4'b0000, 0, 0, "idle1");
        step(0, 1, 1, 1, 4'b0000, 0, 0, "idle2");

        // ring left; mode input toggled while running must be ignored
        step(1, 0, 0, 0, 4'b0001, 0, 0, "ring_seed");
        step(0, 1, 1, 0, 4'b0010, 0, 0, "ring_a1");
        step(0, 1, 1, 0, 4'b0100, 0, 0, "ring_a2");
        step(0, 1, 0, 0, 4'b1000, 0, 0, "ring_a3");
        step(0, 1, 1, 0, 4'b0001, 1, 0, "ring_wrap");
        step(0, 1, 0, 0, 4'b0010, 0, 0, "ring_post");

        // johnson left, start has priority over en
        step(1, 1, 1, 0, 4'b0000, 0, 0, "john_seed");
        step(0, 1, 0, 0, 4'b0001, 0, 0, "john_a1");
        step(0, 1, 0, 0, 4'b0011, 0, 0, "john_a2");
        step(0, 1, 0, 0, 4'b0111, 0, 0, "john_a3");
        step(0, 1, 0, 0, 4'b1111, 0, 0, "john_a4");
        step(0, 1, 0, 0, 4'b1110, 0, 0, "john_a5");
        step(0, 1, 0, 0, 4'b1100, 0, 0, "john_a6");
        step(0, 1, 0, 0, 4'b1000, 0, 0, "john_a7");
        step(0, 1, 0, 0, 4'b0000, 1, 0, "john_wrap");
        step(0, 1, 0, 1, 4'b1000, 0, 0, "john_r1");
        step(0, 1, 0, 1, 4'b1100, 0, 0, "john_r2");
        step(0, 1, 0, 0, 4'b1000, 0, 0, "john_back1");
        step(0, 1, 0, 0, 4'b0000, 1, 0, "john_back_wrap");

        // ring right, hold, then retrace
        step(1, 0, 0, 1, 4'b0001, 0, 0, "rr_seed");
        step(0, 1, 0, 1, 4'b1000, 0, 0, "rr_a1");
        step(0, 1, 0, 1, 4'b0100, 0, 0, "rr_a2");
        step(0, 0, 0, 1, 4'b0100, 0, 0, "rr_hold");
        step(0, 1, 0, 0, 4'b1000, 0, 0, "rr_back1");
        step(0, 1, 0, 0, 4'b0001, 1, 0, "rr_back_wrap");

        // restart mid-sequence never produces wrap
        step(0, 1, 0, 0, 4'b0010, 0, 0, "rs_a1");
        step(0, 1, 0, 0, 4'b0100, 0, 0, "rs_a2");
        step(1, 1, 0, 0, 4'b0001, 0, 0, "rs_restart");
        step(0, 1, 0, 0, 4'b0010, 0, 0, "rs_a3");
        step(0, 1, 0, 0, 4'b0100, 0, 0, "rs_a4");
        step(0, 1, 0, 0, 4'b1000, 0, 0, "rs_a5");
        step(0, 1, 0, 0, 4'b0001, 1, 0, "rs_wrap");

        // asynchronous reset mid-period while wrap is high
        #3;
        rst_n = 1'b0;
        #1;
        sb.push_back('{4'b0000, 1'b0, 1'b0, "async_reset"});
        chk();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0, 4'b0000, 0, 0, "post_reset_idle");
        step(0, 1, 0, 0, 4'b0000, 0, 0, "post_reset_idle2");

        // illegal ring state injected directly into the counter register
        step(1, 0, 0, 0, 4'b0001, 0, 0, "ill_seed");
        @(negedge clk);
        force dut.r_q = 4'b0110;
        #1;
        release dut.r_q;
        start = 1'b0;
        en    = 1'b1;
        mode  = 1'b0;
        dir   = 1'b0;
`ifdef RING_SELF_CORRECT_EN
        sb.push_back('{4'b0001, 1'b0, 1'b1, "ill_fix"});
`else
        sb.push_back('{4'b1100, 1'b0, 1'b0, "ill_prop"});
`endif
        @(posedge clk);
        #1;
        chk();
`ifdef RING_SELF_CORRECT_EN
        step(0, 1, 0, 0, 4'b0010, 0, 0, "ill_after");
`else
        step(0, 1, 0, 0, 4'b1001, 0, 0, "ill_after");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
